// File: rtl/fetch_decode_unit_pkg.sv
// Shared opcode, register and field-position constants for the
// MiniAlu fetch/decode stage and its neighbours.
package fetch_decode_unit_pkg;

   localparam logic [3:0] NOP  = 4'd0;
   localparam logic [3:0] LED  = 4'd1;
   localparam logic [3:0] BLE  = 4'd2;
   localparam logic [3:0] STO  = 4'd3;
   localparam logic [3:0] ADD  = 4'd4;
   localparam logic [3:0] JMP  = 4'd5;
   localparam logic [3:0] SUB  = 4'd6;
   localparam logic [3:0] IMUL = 4'd7;

   localparam logic [7:0] R0 = 8'd0;
   localparam logic [7:0] R1 = 8'd1;
   localparam logic [7:0] R2 = 8'd2;
   localparam logic [7:0] R3 = 8'd3;
   localparam logic [7:0] R4 = 8'd4;
   localparam logic [7:0] R5 = 8'd5;
   localparam logic [7:0] R6 = 8'd6;
   localparam logic [7:0] R7 = 8'd7;

   localparam int OPCODE_MSB  = 27;
   localparam int OPCODE_LSB  = 24;
   localparam int PAYLOAD_MSB = 23;
   localparam int DEST_MSB    = 23;
   localparam int DEST_LSB    = 16;
   localparam int SRC1_MSB    = 15;
   localparam int SRC1_LSB    = 8;
   localparam int SRC2_MSB    = 7;
   localparam int SRC2_LSB    = 0;
   localparam int IMM_MSB     = 15;
   localparam int IMM_LSB     = 0;

   // A NOP with a non-zero payload suspends issue for payload cycles.
   function automatic logic is_delay_nop(input logic [27:0] w);
      return (w[OPCODE_MSB:OPCODE_LSB] == NOP) &&
             (w[PAYLOAD_MSB:0] != 24'd0);
   endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Fetch/decode bus: ROM address/word, execute back-pressure and
// redirect, and the decoded instruction fields (master = fetch unit).
interface fetch_decode_unit_if #(
   parameter int ADDR_WIDTH  = 16,
   parameter int INSTR_WIDTH = 28
);
   logic [ADDR_WIDTH-1:0]  oRomAddress;
   logic [INSTR_WIDTH-1:0] iRomInstruction;
   logic                   iStall;
   logic                   iBranchTaken;
   logic [ADDR_WIDTH-1:0]  iBranchTarget;
   logic                   oValid;
   logic [3:0]             oOpcode;
   logic [7:0]             oDest;
   logic [7:0]             oSrc1;
   logic [7:0]             oSrc2;
   logic [15:0]            oImm;
   logic [ADDR_WIDTH-1:0]  oPC;
   logic                   oDelayBusy;

   modport master (
      output oRomAddress, oValid, oOpcode, oDest, oSrc1,
      output oSrc2, oImm, oPC, oDelayBusy,
      input  iRomInstruction, iStall, iBranchTaken, iBranchTarget
   );

   modport slave (
      input  oRomAddress, oValid, oOpcode, oDest, oSrc1,
      input  oSrc2, oImm, oPC, oDelayBusy,
      output iRomInstruction, iStall, iBranchTaken, iBranchTarget
   );
endinterface

// File: rtl/fetch_decode_unit_nop_delay_counter.sv
// Loadable down-counter timing NOP-delay suspensions.
// Ports: Clock, Reset, iLoad/iLoadValue, iEnable, iClear, oCount, oDone.
module nop_delay_counter #(
   parameter int DELAY_WIDTH = 24
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   iLoad,
   input  logic                   iEnable,
   input  logic                   iClear,
   input  logic [DELAY_WIDTH-1:0] iLoadValue,
   output logic [DELAY_WIDTH-1:0] oCount,
   output logic                   oDone
);
   logic [DELAY_WIDTH-1:0] count_q, count_d;

   // Saturates at zero so a stall spanning the expiry cannot wrap it.
   always_comb begin
      count_d = count_q;
      if (iClear)
         count_d = '0;
      else if (iLoad)
         count_d = iLoadValue;
      else if (iEnable && count_q != '0)
         count_d = count_q - DELAY_WIDTH'(1);
   end

   always_ff @(posedge Clock) begin
      if (Reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign oCount = count_q;
   assign oDone  = (count_q == DELAY_WIDTH'(1));
endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: owns the PC, registers the ROM word and splits it.
// Ports: Clock, Reset (sync, high), bus (fetch_decode_unit_if.master).
module fetch_decode_unit
   import fetch_decode_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    INSTR_WIDTH = 28,
   parameter int                    DELAY_WIDTH = 24,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                 Clock,
   input  logic                 Reset,
   fetch_decode_unit_if.master  bus
);
   typedef enum logic {RUN = 1'b0, DELAY = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   valid_q, valid_d;
   logic                   cnt_ld, cnt_en, cnt_clr, cnt_done;
   logic [DELAY_WIDTH-1:0] cnt;

   nop_delay_counter #(.DELAY_WIDTH(DELAY_WIDTH)) u_cnt (
      .Clock      (Clock),
      .Reset      (Reset),
      .iLoad      (cnt_ld),
      .iEnable    (cnt_en),
      .iClear     (cnt_clr),
      .iLoadValue (DELAY_WIDTH'(bus.iRomInstruction[PAYLOAD_MSB:0])),
      .oCount     (cnt),
      .oDone      (cnt_done)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      opc_d   = opc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      cnt_ld  = 1'b0;
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      if (bus.iBranchTaken) begin
         pc_d    = bus.iBranchTarget;
         valid_d = 1'b0;
         instr_d = '0;
         instr_d[OPCODE_MSB:OPCODE_LSB] = NOP;
         state_d = RUN;
         cnt_clr = 1'b1;
      end else if (bus.iStall) begin
         cnt_en = (state_q == DELAY);
      end else if (state_q == DELAY) begin
         valid_d = 1'b0;
         cnt_en  = 1'b1;
         // Zero count only if a stall swallowed the final tick.
         if (cnt_done || cnt == '0)
            state_d = RUN;
      end else begin
         instr_d = bus.iRomInstruction;
         valid_d = 1'b1;
         opc_d   = pc_q;
         pc_d    = pc_q + ADDR_WIDTH'(1);
         if (is_delay_nop(28'(bus.iRomInstruction))) begin
            state_d = DELAY;
            cnt_ld  = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         opc_q   <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         opc_q   <= opc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign bus.oRomAddress = pc_q;
   assign bus.oValid      = valid_q;
   assign bus.oOpcode     = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign bus.oDest       = instr_q[DEST_MSB:DEST_LSB];
   assign bus.oSrc1       = instr_q[SRC1_MSB:SRC1_LSB];
   assign bus.oSrc2       = instr_q[SRC2_MSB:SRC2_LSB];
   assign bus.oImm        = instr_q[IMM_MSB:IMM_LSB];
   assign bus.oPC         = opc_q;
   assign bus.oDelayBusy  = (state_q == DELAY);
endmodule
